// File: rtl/kbd_disp_pkg.sv
// Shared defaults and display state encoding for the keyboard/display I/O stage.
// Holds the parameter defaults used by the top level and the keyboard queue.
// No logic lives here.
package kbd_disp_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DISP_HOLD_DEF  = 16;

  typedef enum logic {
    DISP_READY = 1'b0,
    DISP_BUSY  = 1'b1
  } disp_state_t;

endpackage

// File: rtl/kbd_disp_io_fifo.sv
// Small synchronous FIFO holding keyboard bytes until the CPU reads them.
// Latency: a push is visible on head after the clock edge that accepts it.
// Backpressure: a push while full (with no pop) is dropped and flagged on overflow.
module io_sync_fifo
  import kbd_disp_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is ignored; a pop frees the slot a same-cycle push needs.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    overflow = push & full & ~do_pop;
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: head is forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kbd_disp_io.sv
// Keyboard/display character I/O between board pins and the accumulator CPU.
// Latency: key byte queued 3 edges after strobe sampled; OUT visible after 1 edge.
// Backpressure: full keyboard queue drops bytes and sets ovr; display paces via fgo.
module kbd_disp_io
  import kbd_disp_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DISP_HOLD  = DISP_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_stb,
  input  logic              inp_rd,
  output logic [DATA_W-1:0] inpr,
  output logic              fgi,
  input  logic              out_wr,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] outr,
  output logic              disp_stb,
  output logic              fgo,
  input  logic              ien,
  output logic              irq,
  output logic              ovr
);

  localparam int CW = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  logic              stb_s1, stb_s2, stb_d;
  logic [DATA_W-1:0] dat_s1, dat_s2;
  logic              key_rise;
  logic [DATA_W-1:0] key_dat;
  logic              fifo_empty, fifo_full, fifo_ovf;

  disp_state_t       state, state_nxt;
  logic [CW-1:0]     busy_cnt;
  logic              cnt_load;

  // Two-stage synchroniser for the strobe, data carried alongside, then a registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_s1   <= 1'b0;
      stb_s2   <= 1'b0;
      stb_d    <= 1'b0;
      dat_s1   <= '0;
      dat_s2   <= '0;
      key_rise <= 1'b0;
      key_dat  <= '0;
    end else begin
      stb_s1   <= kbd_stb;
      stb_s2   <= stb_s1;
      stb_d    <= stb_s2;
      dat_s1   <= kbd_data;
      dat_s2   <= dat_s1;
      key_rise <= stb_s2 & ~stb_d;
      key_dat  <= dat_s2;
    end
  end

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_kbd_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (key_rise),
    .pop      (inp_rd),
    .din      (key_dat),
    .head     (inpr),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_ovf)
  );

  assign fgi = ~fifo_empty;

  // A dropped byte can only come from a full queue.
  always_comb begin
    assert (!fifo_ovf || fifo_full);
  end

  // Sticky overrun: a dropped byte sets it, a successful INP clears it, set wins.
  always_ff @(posedge clk) begin
    if (rst)                ovr <= 1'b0;
    else if (fifo_ovf)      ovr <= 1'b1;
    else if (inp_rd && fgi) ovr <= 1'b0;
  end

  // Display state register.
  always_ff @(posedge clk) begin
    if (rst) state <= DISP_READY;
    else     state <= state_nxt;
  end

  // Display next state: OUT starts a busy period, counter expiry ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      DISP_READY: if (out_wr)          state_nxt = DISP_BUSY;
      DISP_BUSY:  if (busy_cnt == '0)  state_nxt = DISP_READY;
      default:                         state_nxt = DISP_READY;
    endcase
  end

  // Display outputs: ready flag, and counter load only on an OUT that starts a busy period.
  always_comb begin
    fgo      = (state == DISP_READY);
    cnt_load = (state == DISP_READY) && out_wr;
  end

  // Busy counter; an OUT during BUSY deliberately does not reload it.
  always_ff @(posedge clk) begin
    if (rst)                                     busy_cnt <= '0;
    else if (cnt_load)                           busy_cnt <= CW'(DISP_HOLD - 1);
    else if (state == DISP_BUSY && busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
  end

  // Display register and update pulse follow every OUT regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      outr     <= '0;
      disp_stb <= 1'b0;
    end else begin
      disp_stb <= out_wr;
      if (out_wr) outr <= out_data;
    end
  end

  // Registered interrupt request from the current flag values.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ien & (fgi | fgo);
  end

endmodule
